// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: load/store/LL/SC over a word-wide request/ready bus,
// with big-endian lane steering, load extension and the LL/SC link register.

module data_mem_lane #(
  parameter int LANE = 0
) (
  input  logic       acc_byte,
  input  logic       acc_half,
  input  logic [1:0] off,
  input  logic [7:0] w_word,
  input  logic [7:0] w_hi,
  input  logic [7:0] w_lo,
  output logic       we,
  output logic [7:0] wbyte
);
  // Big-endian: lane 3 (bits 31:24) is byte offset 0.
  localparam logic [1:0] POS = 2'(3 - LANE);

  always_comb begin
    we    = 1'b1;
    wbyte = w_word;
    if (acc_byte) begin
      we    = (off == POS);
      wbyte = w_lo;
    end else if (acc_half) begin
      we    = (off[1] == POS[1]);
      wbyte = POS[0] ? w_lo : w_hi;
    end
  end
endmodule

module data_mem_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Byte,
  input  logic        MEM_Half,
  input  logic        MEM_SignExtend,
  input  logic        MEM_LLSC,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_WriteData,
  input  logic        MEM_Stall,
  input  logic        LLSC_Clear,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_Stall_Controller,
  output logic        MEM_AddrErr,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ready,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_Out
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Attributes of the in-flight access needed at completion.
  typedef struct packed {
    logic       ld;
    logic       st;
    logic       llsc;
    logic       byt;
    logic       half;
    logic       sext;
    logic [1:0] off;
  } acc_t;

  state_t      state, state_nx;
  acc_t        acc_q;
  logic        rd_q;
  logic [3:0]  we_q;
  logic [29:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic        llsc_valid;
  logic [29:0] llsc_addr;

  logic is_rd, is_wr, acc_word, addr_err, sc_fail, req, launch, complete;

  // Read+write together is illegal and degrades to a plain read.
  assign is_rd    = MEM_MemRead;
  assign is_wr    = MEM_MemWrite & ~MEM_MemRead;
  assign acc_word = ~MEM_Byte & ~MEM_Half;
  assign addr_err = (MEM_MemRead | MEM_MemWrite) &
                    ((acc_word & (|MEM_Address[1:0])) |
                     (~MEM_Byte & MEM_Half & MEM_Address[0]));
  assign sc_fail  = is_wr & MEM_LLSC &
                    (~llsc_valid | (MEM_Address[31:2] != llsc_addr));
  assign req      = (is_rd | is_wr) & ~addr_err & ~sc_fail;
  assign launch   = (state == IDLE) & req;
  assign complete = (state == ACCESS) & DataMem_Ready;

  assign MEM_AddrErr          = addr_err;
  assign MEM_Stall_Controller = (state == ACCESS) | launch;
  assign MEM_ReadData         = (state == DONE) ? rdata_q : 32'd0;
  assign DataMem_Read         = rd_q;
  assign DataMem_Write        = we_q;
  assign DataMem_Address      = addr_q;
  assign DataMem_Out          = wd_q;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      data_mem_lane #(.LANE(i)) u_lane (
        .acc_byte (MEM_Byte),
        .acc_half (MEM_Half),
        .off      (MEM_Address[1:0]),
        .w_word   (MEM_WriteData[8*i +: 8]),
        .w_hi     (MEM_WriteData[15:8]),
        .w_lo     (MEM_WriteData[7:0]),
        .we       (lane_we[i]),
        .wbyte    (lane_wd[i])
      );
    end
  endgenerate

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = ACCESS;
      ACCESS:  if (DataMem_Ready) state_nx = DONE;
      DONE:    if (!MEM_Stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    rd_byte = 8'd0;
    case (acc_q.off)
      2'd0:    rd_byte = DataMem_In[31:24];
      2'd1:    rd_byte = DataMem_In[23:16];
      2'd2:    rd_byte = DataMem_In[15:8];
      default: rd_byte = DataMem_In[7:0];
    endcase
    rd_half = acc_q.off[1] ? DataMem_In[15:0] : DataMem_In[31:16];
    rd_ext  = DataMem_In;
    if (acc_q.byt)
      rd_ext = {{24{acc_q.sext & rd_byte[7]}}, rd_byte};
    else if (acc_q.half)
      rd_ext = {{16{acc_q.sext & rd_half[15]}}, rd_half};
  end

  // Bus strobes are registered so they stay stable for the whole access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      rd_q    <= 1'b0;
      we_q    <= 4'd0;
      addr_q  <= 30'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else if (launch) begin
      acc_q   <= '{ld: is_rd, st: is_wr, llsc: MEM_LLSC, byt: MEM_Byte,
                   half: MEM_Half, sext: MEM_SignExtend, off: MEM_Address[1:0]};
      rd_q    <= is_rd;
      we_q    <= is_wr ? lane_we : 4'd0;
      addr_q  <= MEM_Address[31:2];
      wd_q    <= lane_wd;
    end else if (complete) begin
      rd_q    <= 1'b0;
      we_q    <= 4'd0;
      rdata_q <= acc_q.st ? {31'd0, acc_q.llsc} : rd_ext;
    end
  end

  // An external clear wins over an LL completing on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      llsc_valid <= 1'b0;
      llsc_addr  <= 30'd0;
    end else if (LLSC_Clear) begin
      llsc_valid <= 1'b0;
    end else if (complete & acc_q.ld & acc_q.llsc) begin
      llsc_valid <= 1'b1;
      llsc_addr  <= addr_q;
    end else if (complete & acc_q.st & (addr_q == llsc_addr)) begin
      llsc_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: vector table plus LL/SC and reset sequences.

module tb_data_mem_controller;
  logic        clock, reset;
  logic        mem_read, mem_write, mem_byte, mem_half, mem_sext, mem_llsc;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, if_stall, llsc_clear;
  logic [31:0] mem_rdata;
  logic        stall_ctrl, addr_err;
  logic [31:0] dm_in;
  logic        dm_ready, dm_read;
  logic [3:0]  dm_write;
  logic [29:0] dm_addr;
  logic [31:0] dm_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  assign mem_stall = stall_ctrl | if_stall;

  data_mem_controller dut (
    .clock(clock), .reset(reset),
    .MEM_MemRead(mem_read), .MEM_MemWrite(mem_write), .MEM_Byte(mem_byte),
    .MEM_Half(mem_half), .MEM_SignExtend(mem_sext), .MEM_LLSC(mem_llsc),
    .MEM_Address(mem_addr), .MEM_WriteData(mem_wdata), .MEM_Stall(mem_stall),
    .LLSC_Clear(llsc_clear), .MEM_ReadData(mem_rdata),
    .MEM_Stall_Controller(stall_ctrl), .MEM_AddrErr(addr_err),
    .DataMem_In(dm_in), .DataMem_Ready(dm_ready), .DataMem_Read(dm_read),
    .DataMem_Write(dm_write), .DataMem_Address(dm_addr), .DataMem_Out(dm_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        rd, wr, byt, half, sext, llsc;
    logic [31:0] addr, wdata, bus_in;
    int          waits, extra;
    logic        err, bus;
    logic [3:0]  we;
    logic [31:0] outv, rdata;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic byt, logic half, logic sext,
                              logic llsc, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] bus_in, int waits, int extra, logic err,
                              logic bus, logic [3:0] we, logic [31:0] outv,
                              logic [31:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.byt = byt; v.half = half; v.sext = sext; v.llsc = llsc;
    v.addr = addr; v.wdata = wdata; v.bus_in = bus_in; v.waits = waits; v.extra = extra;
    v.err = err; v.bus = bus; v.we = we; v.outv = outv; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; mem_byte = 0; mem_half = 0; mem_sext = 0; mem_llsc = 0;
    mem_addr = 0; mem_wdata = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_n, rd_n;
    logic [31:0] held;
    mem_read = v.rd; mem_write = v.wr; mem_byte = v.byt; mem_half = v.half;
    mem_sext = v.sext; mem_llsc = v.llsc; mem_addr = v.addr; mem_wdata = v.wdata;
    #1;
    chk("addr_err", {31'd0, addr_err}, {31'd0, v.err});
    chk("stall_req", {31'd0, stall_ctrl}, {31'd0, v.bus});
    if (!v.bus) begin
      chk("rdata_nobus", mem_rdata, v.rdata);
      step();
      chk("nobus_read", {31'd0, dm_read}, 32'd0);
      chk("nobus_write", {28'd0, dm_write}, 32'd0);
      chk("nobus_stall", {31'd0, stall_ctrl}, 32'd0);
      idle_inputs();
      return;
    end
    exp_q.push_back(v.rdata);
    stall_n = stall_ctrl ? 1 : 0;
    rd_n = 0;
    for (int c = 0; c <= v.waits; c++) begin
      step();
      if (stall_ctrl) stall_n++;
      if (dm_read) rd_n++;
      chk("bus_we", {28'd0, dm_write}, {28'd0, v.we});
      chk("bus_addr", {2'd0, dm_addr}, {2'd0, v.addr[31:2]});
      if (v.we != 4'd0) chk("bus_out", dm_out, v.outv);
      if (c == v.waits) begin
        dm_ready = 1'b1;
        dm_in = v.bus_in;
      end
    end
    step();
    dm_ready = 1'b0;
    dm_in = 32'd0;
    chk("stall_cycles", stall_n, 32'(v.waits + 2));
    chk("read_cycles", rd_n, v.rd ? 32'(v.waits + 1) : 32'd0);
    chk("done_stall", {31'd0, stall_ctrl}, 32'd0);
    chk("done_strobes", {27'd0, dm_read, dm_write}, 32'd0);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue at completion");
    end else begin
      chk("rdata", mem_rdata, exp_q.pop_front());
    end
    held = mem_rdata;
    if (v.extra > 0) begin
      if_stall = 1'b1;
      for (int e = 0; e < v.extra; e++) begin
        step();
        chk("hold_rdata", mem_rdata, held);
        chk("hold_strobes", {27'd0, dm_read, dm_write}, 32'd0);
        chk("hold_stall", {31'd0, stall_ctrl}, 32'd0);
      end
      if_stall = 1'b0;
    end
    idle_inputs();
    step();
    chk("back_idle_rdata", mem_rdata, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    //           rd wr by hf sx ll addr          wdata         bus_in        w  x  er bus we       out           rdata
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 0, 1, 4'b0000, 32'h0,        32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 32'h103, 32'h0,        32'h000000F0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFFFFF0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 32'h103, 32'h0,        32'h000000F0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h000000F0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32'h202, 32'hABCD1234, 32'h0,        0, 0, 0, 1, 4'b0011, 32'h12341234, 32'h0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h100, 32'h0,        32'h12345678, 1, 3, 0, 1, 4'b0000, 32'h0,        32'h12345678));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h101, 32'h0,        32'h0,        0, 0, 1, 0, 4'b0000, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 32'h200, 32'h0,        32'h80017FFF, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 32'h202, 32'h0,        32'h80017FFF, 1, 0, 0, 1, 4'b0000, 32'h0,        32'h00007FFF));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h001, 32'h000000A5, 32'h0,        0, 0, 0, 1, 4'b0100, 32'hA5A5A5A5, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h010, 32'h11223344, 32'h0,        0, 0, 0, 1, 4'b1111, 32'h11223344, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32'h203, 32'h0,        32'h0,        0, 0, 1, 0, 4'b0000, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h800, 32'hFFFFFFFF, 32'h00000099, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h00000099));
    // LL then SC succeeds once, second SC fails without touching the bus
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h300, 32'h0,        32'hCAFEF00D, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h300, 32'h00000055, 32'h0,        0, 0, 0, 1, 4'b1111, 32'h00000055, 32'h1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h300, 32'h00000055, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
    // plain store to the linked word breaks the link
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h600, 32'h0,        32'h00000001, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h00000001));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h600, 32'h00000007, 32'h0,        0, 0, 0, 1, 4'b1111, 32'h00000007, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h600, 32'h00000009, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
    // SC to another word fails but keeps the link
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h700, 32'h0,        32'h00000002, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h00000002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h704, 32'h00000003, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h700, 32'h00000004, 32'h0,        2, 0, 0, 1, 4'b1111, 32'h00000004, 32'h1));
  end

  initial begin
    reset = 1'b0;
    if_stall = 1'b0; llsc_clear = 1'b0;
    dm_in = 32'd0; dm_ready = 1'b0;
    idle_inputs();
    #1;
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", {31'd0, stall_ctrl}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_strobes", {27'd0, dm_read, dm_write}, 32'd0);
    chk("rst_bus_addr", {2'd0, dm_addr}, 32'd0);
    chk("rst_bus_out", dm_out, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset pulse in the middle of an access
    run_vec(mk(1, 0, 0, 0, 0, 1, 32'h300, 32'h0, 32'h0BADF00D, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h0BADF00D));
    mem_read = 1'b1; mem_addr = 32'h400;
    step();
    chk("mid_access_read", {31'd0, dm_read}, 32'd1);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("async_rst_read", {31'd0, dm_read}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_ctrl}, 32'd0);
    chk("async_rst_addr", {2'd0, dm_addr}, 32'd0);
    step();
    reset = 1'b1;
    dm_ready = 1'b1; dm_in = 32'h55555555;
    step();
    dm_ready = 1'b0; dm_in = 32'd0;
    chk("late_ready_rdata", mem_rdata, 32'd0);
    chk("late_ready_stall", {31'd0, stall_ctrl}, 32'd0);
    step();
    chk("late_ready_rdata2", mem_rdata, 32'd0);
    run_vec(mk(0, 1, 0, 0, 0, 1, 32'h300, 32'h1, 32'h0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0));

    // explicit link clear
    run_vec(mk(1, 0, 0, 0, 0, 1, 32'h500, 32'h0, 32'h00000005, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000005));
    llsc_clear = 1'b1;
    step();
    llsc_clear = 1'b0;
    run_vec(mk(0, 1, 0, 0, 0, 1, 32'h500, 32'h1, 32'h0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0));

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: %0d results never produced", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- MEM-stage data memory controller for the MIPS pipeline.
- Turns MEM-stage load/store/LL/SC requests into a word-wide request/ready memory bus transaction.
- Performs big-endian byte/half lane steering and extension, and tracks the LL/SC link.
- Drives MEM_Stall_Controller into the hazard detection unit, which keeps the pipeline frozen while an access is in flight.

Parameters:
- none (32-bit datapath, 30-bit word bus address fixed)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MEM_MemRead  in  1  load (including LL) in MEM stage
- MEM_MemWrite  in  1  store (including SC) in MEM stage
- MEM_Byte  in  1  byte-size access
- MEM_Half  in  1  halfword-size access; word size when both MEM_Byte and MEM_Half are 0
- MEM_SignExtend  in  1  sign-extend byte/half loads
- MEM_LLSC  in  1  with MemRead: LL; with MemWrite: SC
- MEM_Address  in  32  byte address
- MEM_WriteData  in  32  store data, already forwarded
- MEM_Stall  in  1  global MEM stall; 0 means the MEM instruction retires this edge
- LLSC_Clear  in  1  exception/ERET; clears the link
- MEM_ReadData  out  32  load result, or SC status (1/0)
- MEM_Stall_Controller  out  1  to hazard unit
- MEM_AddrErr  out  1  unaligned access
- DataMem_In  in  32  bus read data
- DataMem_Ready  in  1  bus completion, single-cycle pulse
- DataMem_Read  out  1  bus read strobe
- DataMem_Write  out  4  byte write enables; bit3 = bits 31:24
- DataMem_Address  out  30  word address (MEM_Address[31:2])
- DataMem_Out  out  32  lane-steered write data

Behaviour:
- Reset (reset=0, async) forces:
  - state IDLE, all bus strobes 0, LLSC_Valid 0
  - captured data register 0, MEM_ReadData 0
  - MEM_Stall_Controller 0, MEM_AddrErr 0
- Mid-access reset abandons the bus transaction; a late DataMem_Ready in IDLE is ignored.
- MEM_AddrErr is combinational and is 1 when MemRead|MemWrite and either:
  - word access with Address[1:0]!=0, or
  - half access with Address[0]!=0
  - An address error never starts an access and never stalls.
- SC fails when !LLSC_Valid or Address[31:2]!=LLSC_Addr:
  - no bus access, no stall, MEM_ReadData=0.
- SC success writes memory; MEM_ReadData=1 in DONE.
- State machine IDLE / ACCESS / DONE:
  - IDLE:
    - Access request = (MemRead|MemWrite) & !AddrErr & !SCfail.
    - MEM_Stall_Controller = request (combinational).
    - On request go to ACCESS; latch address, strobes and steered data.
  - ACCESS:
    - DataMem_Read or DataMem_Write held registered-stable; MEM_Stall_Controller=1.
    - On DataMem_Ready: capture the extended read result (or SC status), drop strobes the same edge, go to DONE.
  - DONE:
    - MEM_Stall_Controller=0; MEM_ReadData = captured value.
    - If MEM_Stall=0, go to IDLE. Otherwise hold (e.g. frozen by IF stall); never re-issue.
- Latency with zero-wait memory (Ready in first ACCESS cycle) is 3 cycles: IDLE-stall, ACCESS, DONE. Each wait cycle adds 1.
- Write lanes, big-endian:
  - byte: enable = 4'b1000>>Address[1:0]; data byte replicated ×4
  - half: 4'b1100 at offset 0, 4'b0011 at offset 2; half replicated ×2
  - word: 4'b1111
- Read extraction mirrors the write lanes; zero- or sign-extends per MEM_SignExtend.
- LL link register:
  - A completed LL sets LLSC_Valid=1 and LLSC_Addr=Address[31:2].
  - Any completed store (including SC) to LLSC_Addr clears LLSC_Valid.
  - LLSC_Clear clears LLSC_Valid. It has priority over a simultaneous LL set.
- MemRead and MemWrite both 1 is illegal: treated as a read, no write.

Test Plan:
- Word load 0x100, Ready after 2 wait cycles with DataMem_In=0xDEADBEEF, MEM_Stall follows the controller:
  - Stall_Controller high 4 cycles; DataMem_Read high 3 cycles.
  - MEM_ReadData=0xDEADBEEF in DONE; returns to IDLE next edge.
- Signed byte load at 0x103 with DataMem_In=0x000000F0 -> 0xFFFFFFF0. Unsigned -> 0x000000F0.
- Half store 0xABCD1234 at 0x202, zero-wait:
  - DataMem_Write=4'b0011, DataMem_Out=0x12341234, DataMem_Address=0x80.
  - Latency 3 cycles.
- Access completes while MEM_Stall stays 1 for 3 extra cycles (IF stall):
  - Controller stays in DONE, no second strobe, MEM_ReadData stable.
- Unaligned word load at 0x101 -> MEM_AddrErr=1, no DataMem_Read, Stall_Controller=0.
- LL 0x300, then SC 0x300 -> write issued, MEM_ReadData=1. Second SC 0x300 -> no bus write, MEM_ReadData=0, no stall. Pulse reset during ACCESS -> strobes drop immediately, LLSC_Valid=0.
